// File: rtl/gf180mcu_fd_sc_mcu7t5v0__scan_tail_rx.sv
// gf180mcu_fd_sc_mcu7t5v0__scan_tail_rx: scan-chain tail deserializer with a small output FIFO
module gf180mcu_fd_sc_mcu7t5v0__scan_tail_rx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SE,
  input  logic             SI,
  input  logic             FLUSH,
  input  logic             READY,
  output logic [WIDTH-1:0] DATA,
  output logic             VALID,
  output logic [CW-1:0]    CNT,
  output logic             BUSY,
  output logic             OVF
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sreg, word;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] occ;
  logic done, flush_ok, push, pop, full, wr_en;
  // Word assembly, push/pop decisions and next state
  always_comb begin
    done = SE && (CNT == CW'(WIDTH - 1));
    flush_ok = !SE && FLUSH && (CNT != '0);
    push = done || flush_ok;
    word = SE ? (sreg | ({{(WIDTH-1){1'b0}}, SI} << CNT)) : sreg;
    full = occ == (AW+1)'(DEPTH);
    pop = VALID && READY;
    wr_en = push && (!full || pop);
    state_nx = push ? IDLE : (SE ? SHIFT : state);
  end
  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else state <= state_nx;
  end
  // Shift register and bit counter; a push always restarts the word from zero
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sreg <= '0;
      CNT <= '0;
    end else begin
      sreg <= push ? '0 : word;
      CNT <= push ? '0 : (SE ? CNT + 1'b1 : CNT);
    end
  end
  // FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      OVF <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= word;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + (AW+1)'(wr_en) - (AW+1)'(pop);
      OVF <= OVF | (push && full && !pop);
    end
  end
  assign DATA = mem[rd_ptr];
  assign VALID = occ != '0;
  assign BUSY = state == SHIFT;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__scan_tail_rx.sv
// tb_gf180mcu_fd_sc_mcu7t5v0__scan_tail_rx: directed plus randomized checks against a queue-based model
module tb_gf180mcu_fd_sc_mcu7t5v0__scan_tail_rx;
  localparam int W = 8;
  localparam int D = 2;
  logic CLK = 1'b0, RST = 1'b1, SE = 1'b0, SI = 1'b0, FLUSH = 1'b0, READY = 1'b0;
  logic [W-1:0] DATA;
  logic VALID, BUSY, OVF;
  logic [3:0] CNT;
  int tests = 0, fails = 0;
  logic [W-1:0] m_fifo[$];
  bit m_part[$];
  bit m_ovf;
  gf180mcu_fd_sc_mcu7t5v0__scan_tail_rx #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(CLK), .RST(RST), .SE(SE), .SI(SI), .FLUSH(FLUSH), .READY(READY),
    .DATA(DATA), .VALID(VALID), .CNT(CNT), .BUSY(BUSY), .OVF(OVF)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_fifo = {};
    m_part = {};
    m_ovf = 1'b0;
  endtask
  task automatic model_step(input bit se, input bit si, input bit fl, input bit rd);
    logic [W-1:0] w;
    bit push, pop, full;
    push = 0;
    w = '0;
    full = m_fifo.size() == D;
    pop = m_fifo.size() > 0 && rd;
    if (se) begin
      m_part.push_back(si);
      if (m_part.size() == W) push = 1;
    end else if (fl && m_part.size() > 0) push = 1;
    if (push) begin
      foreach (m_part[i]) w[i] = m_part[i];
      m_part = {};
    end
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      if (full && !pop) m_ovf = 1'b1;
      else m_fifo.push_back(w);
    end
  endtask
  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 32'(VALID), 32'(m_fifo.size() > 0));
    chk({tag, ".cnt"}, 32'(CNT), 32'(m_part.size()));
    chk({tag, ".busy"}, 32'(BUSY), 32'(m_part.size() > 0));
    chk({tag, ".ovf"}, 32'(OVF), 32'(m_ovf));
    if (m_fifo.size() > 0) chk({tag, ".data"}, 32'(DATA), 32'(m_fifo[0]));
  endtask
  task automatic cyc(input bit se, input bit si, input bit fl, input bit rd, input string tag);
    SE = se;
    SI = si;
    FLUSH = fl;
    READY = rd;
    @(posedge CLK);
    model_step(se, si, fl, rd);
    @(negedge CLK);
    check_model(tag);
  endtask
  task automatic shift_word(input logic [W-1:0] w, input bit rd_last, input string tag);
    for (int i = 0; i < W; i++) cyc(1'b1, w[i], 1'b0, (i == W - 1) && rd_last, tag);
  endtask
  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    #1;
    model_reset();
    chk("rst.cnt", 32'(CNT), 0);
    chk("rst.valid", 32'(VALID), 0);
    chk("rst.busy", 32'(BUSY), 0);
    chk("rst.ovf", 32'(OVF), 0);
    chk("rst.data", 32'(DATA), 0);
    #1;
    RST = 1'b0;
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge CLK);
    chk("init.data", 32'(DATA), 0);
    chk("init.valid", 32'(VALID), 0);
    chk("init.cnt", 32'(CNT), 0);
    chk("init.busy", 32'(BUSY), 0);
    chk("init.ovf", 32'(OVF), 0);
    RST = 1'b0;
    shift_word(8'h4D, 1'b0, "w4d");
    chk("w4d.data", 32'(DATA), 32'h4D);
    chk("w4d.valid", 32'(VALID), 1);
    chk("w4d.cnt", 32'(CNT), 0);
    cyc(0, 0, 0, 1, "pop4d");
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, "part");
    chk("part.cnt3", 32'(CNT), 3);
    chk("part.busy", 32'(BUSY), 1);
    cyc(0, 0, 0, 0, "hold");
    cyc(0, 0, 1, 0, "flush");
    chk("flush.data", 32'(DATA), 32'h07);
    chk("flush.cnt", 32'(CNT), 0);
    chk("flush.busy", 32'(BUSY), 0);
    cyc(0, 0, 1, 1, "flush0");
    chk("flush0.valid", 32'(VALID), 0);
    shift_word(8'hA5, 1'b0, "ovA");
    shift_word(8'h3C, 1'b0, "ovB");
    shift_word(8'hFF, 1'b0, "ovC");
    chk("ov.flag", 32'(OVF), 1);
    chk("ov.head", 32'(DATA), 32'hA5);
    cyc(0, 0, 0, 1, "ovpop1");
    chk("ov.second", 32'(DATA), 32'h3C);
    cyc(0, 0, 0, 1, "ovpop2");
    chk("ov.empty", 32'(VALID), 0);
    chk("ov.sticky", 32'(OVF), 1);
    do_reset();
    shift_word(8'hA5, 1'b0, "fsA");
    shift_word(8'h3C, 1'b0, "fsB");
    shift_word(8'hFF, 1'b1, "fsC");
    chk("fs.ovf", 32'(OVF), 0);
    chk("fs.head", 32'(DATA), 32'h3C);
    cyc(0, 0, 0, 1, "fspop1");
    chk("fs.next", 32'(DATA), 32'hFF);
    cyc(0, 0, 0, 1, "fspop2");
    chk("fs.empty", 32'(VALID), 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, "mid");
    do_reset();
    shift_word(8'h96, 1'b0, "clean");
    chk("clean.data", 32'(DATA), 32'h96);
    cyc(0, 0, 0, 1, "cleanpop");
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, "sf");
    cyc(1, 1, 1, 0, "sfl");
    chk("sfl.cnt", 32'(CNT), 5);
    chk("sfl.valid", 32'(VALID), 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, "sfend");
    chk("sfend.data", 32'(DATA), 32'hF0);
    cyc(0, 0, 0, 1, "sfpop");
    for (int n = 0; n < 400; n++)
      cyc(($urandom % 4) != 0, $urandom % 2, ($urandom % 8) == 0, ($urandom % 3) == 0, "rnd");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
